vmac_array: RTL and testbench

VMAC_ARRAY -- requirements
Module: vmac_array

---
 rtl/vmac_array.sv | 217 +++++++++++++++++++++
 tb/tb_vmac_array.sv | 399 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vmac_array.sv
// vmac_array: LANES-wide multiply-accumulate pipeline.
//   y[i] = a[i]*b[i] + addend[i], where addend is c[i] or the lane accumulator.
//   Three stages: S0 input register, S1 product register, S2 output/accumulator.
//   Optional saturation, signed or unsigned operation, per-lane bypass mask.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   in_valid/in_ready       input beat handshake
//   a, b                    LANES x EW operands, lane i at [i*EW +: EW]
//   c                       LANES x AW external addend, lane i at [i*AW +: AW]
//   lane_mask               1 = lane bypassed (outputs addend, acc untouched)
//   op_signed/op_sat/op_acc per-beat operation controls
//   out_valid/out_ready     output beat handshake
//   y, y_sat                per-lane result and clamp flag

// Per-lane datapath: the S0->S1 multiplier and the S2 add/clamp.
module vmac_lane #(
    parameter int EW = 16,
    parameter int AW = 32
) (
    input  logic [EW-1:0]     i_a,
    input  logic [EW-1:0]     i_b,
    input  logic              i_mul_sgn,
    output logic [2*EW+1:0]   o_prod,
    input  logic [2*EW+1:0]   i_prod,
    input  logic [AW-1:0]     i_addend,
    input  logic              i_sgn,
    input  logic              i_sat,
    input  logic              i_mask,
    output logic [AW-1:0]     o_y,
    output logic              o_sat
);
    localparam int PW = 2*EW + 2;
    localparam int SW = ((AW > PW) ? AW : PW) + 1;

    // Operands extended to EW+1 bits, then to full product width so a
    // plain multiply yields the correct two's-complement product.
    logic [PW-1:0] w_ax, w_bx;
    assign w_ax = {{(EW+2){i_mul_sgn & i_a[EW-1]}}, i_a};
    assign w_bx = {{(EW+2){i_mul_sgn & i_b[EW-1]}}, i_b};
    assign o_prod = w_ax * w_bx;

    logic [SW-1:0] w_pext, w_aext, w_sum;
    assign w_pext = {{(SW-PW){i_prod[PW-1]}}, i_prod};
    assign w_aext = {{(SW-AW){i_sgn & i_addend[AW-1]}}, i_addend};
    assign w_sum  = w_pext + w_aext;

    // Signed range fits iff bits [SW-1:AW-1] are all equal; unsigned range
    // fits iff the sum is non-negative and bits [SW-1:AW] are zero.
    logic w_shi, w_slo, w_uhi, w_neg;
    assign w_neg = w_sum[SW-1];
    assign w_shi = ~w_neg & (|w_sum[SW-1:AW-1]);
    assign w_slo =  w_neg & ~(&w_sum[SW-1:AW-1]);
    assign w_uhi = ~w_neg & (|w_sum[SW-1:AW]);

    always_comb begin
        o_y   = w_sum[AW-1:0];
        o_sat = 1'b0;
        if (i_mask) begin
            o_y = i_addend;
        end else if (i_sat) begin
            if (i_sgn) begin
                if (w_shi) begin
                    o_y   = {1'b0, {(AW-1){1'b1}}};
                    o_sat = 1'b1;
                end else if (w_slo) begin
                    o_y   = {1'b1, {(AW-1){1'b0}}};
                    o_sat = 1'b1;
                end
            end else begin
                if (w_neg) begin
                    o_y   = '0;
                    o_sat = 1'b1;
                end else if (w_uhi) begin
                    o_y   = '1;
                    o_sat = 1'b1;
                end
            end
        end
    end
endmodule

module vmac_array #(
    parameter int LANES = 4,
    parameter int EW    = 16,
    parameter int AW    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*EW-1:0] a,
    input  logic [LANES*EW-1:0] b,
    input  logic [LANES*AW-1:0] c,
    input  logic [LANES-1:0]    lane_mask,
    input  logic                op_signed,
    input  logic                op_sat,
    input  logic                op_acc,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LANES*AW-1:0] y,
    output logic [LANES-1:0]    y_sat
);
    localparam int PW = 2*EW + 2;

    logic [LANES-1:0][EW-1:0] w_a, w_b;
    logic [LANES-1:0][AW-1:0] w_c;
    assign w_a = a;
    assign w_b = b;
    assign w_c = c;

    // Per-stage valids: [0]=S0, [1]=S1, [2]=S2 (out_valid).
    logic [2:0] r_vld;
    logic [2:0] w_adv;

    logic [LANES-1:0][EW-1:0] r_a0, r_b0;
    logic [LANES-1:0][AW-1:0] r_c0;
    logic [LANES-1:0]         r_mask0;
    logic                     r_sgn0, r_sat0, r_acc0;

    logic [LANES-1:0][PW-1:0] r_prod1;
    logic [LANES-1:0][AW-1:0] r_c1;
    logic [LANES-1:0]         r_mask1;
    logic                     r_sgn1, r_sat1, r_acc1;

    logic [LANES-1:0][AW-1:0] r_y, r_acc;
    logic [LANES-1:0]         r_ysat;

    logic [LANES-1:0][PW-1:0] w_prod;
    logic [LANES-1:0][AW-1:0] w_addend, w_y;
    logic [LANES-1:0]         w_ysat;

    assign w_adv[2] = ~r_vld[2] | out_ready;
    assign w_adv[1] = ~r_vld[1] | w_adv[2];
    assign w_adv[0] = ~r_vld[0] | w_adv[1];

    assign in_ready  = w_adv[0];
    assign out_valid = r_vld[2];
    assign y         = r_y;
    assign y_sat     = r_ysat;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // acc is written on the edge that retires the previous beat, so the
        // beat now in S1 always sees an up-to-date accumulator.
        assign w_addend[i] = r_acc1 ? r_acc[i] : r_c1[i];

        vmac_lane #(.EW(EW), .AW(AW)) u_lane (
            .i_a      (r_a0[i]),
            .i_b      (r_b0[i]),
            .i_mul_sgn(r_sgn0),
            .o_prod   (w_prod[i]),
            .i_prod   (r_prod1[i]),
            .i_addend (w_addend[i]),
            .i_sgn    (r_sgn1),
            .i_sat    (r_sat1),
            .i_mask   (r_mask1[i]),
            .o_y      (w_y[i]),
            .o_sat    (w_ysat[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_a0    <= '0;
            r_b0    <= '0;
            r_c0    <= '0;
            r_mask0 <= '0;
            r_sgn0  <= 1'b0;
            r_sat0  <= 1'b0;
            r_acc0  <= 1'b0;
            r_prod1 <= '0;
            r_c1    <= '0;
            r_mask1 <= '0;
            r_sgn1  <= 1'b0;
            r_sat1  <= 1'b0;
            r_acc1  <= 1'b0;
            r_y     <= '0;
            r_ysat  <= '0;
            r_acc   <= '0;
        end else begin
            // Data registers only load with a real beat to avoid needless toggling.
            if (w_adv[0]) begin
                r_vld[0] <= in_valid;
                if (in_valid) begin
                    r_a0    <= w_a;
                    r_b0    <= w_b;
                    r_c0    <= w_c;
                    r_mask0 <= lane_mask;
                    r_sgn0  <= op_signed;
                    r_sat0  <= op_sat;
                    r_acc0  <= op_acc;
                end
            end
            if (w_adv[1]) begin
                r_vld[1] <= r_vld[0];
                if (r_vld[0]) begin
                    r_prod1 <= w_prod;
                    r_c1    <= r_c0;
                    r_mask1 <= r_mask0;
                    r_sgn1  <= r_sgn0;
                    r_sat1  <= r_sat0;
                    r_acc1  <= r_acc0;
                end
            end
            if (w_adv[2]) begin
                r_vld[2] <= r_vld[1];
                if (r_vld[1]) begin
                    r_y    <= w_y;
                    r_ysat <= w_ysat;
                    for (int i = 0; i < LANES; i++) begin
                        if (!r_mask1[i]) r_acc[i] <= w_y[i];
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_vmac_array.sv
module tb_vmac_array;
    localparam int LANES = 4;
    localparam int EW    = 16;
    localparam int AW    = 32;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [LANES*EW-1:0] a = '0;
    logic [LANES*EW-1:0] b = '0;
    logic [LANES*AW-1:0] c = '0;
    logic [LANES-1:0]    lane_mask = '0;
    logic                op_signed = 1'b0;
    logic                op_sat = 1'b0;
    logic                op_acc = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [LANES*AW-1:0] y;
    logic [LANES-1:0]    y_sat;

    always #5 clk = ~clk;

    vmac_array #(.LANES(LANES), .EW(EW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .lane_mask(lane_mask), .op_signed(op_signed),
        .op_sat(op_sat), .op_acc(op_acc), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .y_sat(y_sat)
    );

    typedef struct {
        logic [LANES*AW-1:0] y;
        logic [LANES-1:0]    s;
        int                  cyc;
    } res_t;

    res_t             exp_q[$];
    res_t             rcv_q[$];
    logic [AW-1:0]    mdl_acc[LANES];
    int               cyc = 0;
    int               n_vec = 0;
    int               n_err = 0;
    bit               rnd_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every beat the downstream actually takes.
    always @(negedge clk) begin : mon
        res_t r;
        if (rst_n && out_valid && out_ready) begin
            r.y = y; r.s = y_sat; r.cyc = cyc;
            rcv_q.push_back(r);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need completion");
        $fatal(1);
    end

    // Reference: each lane is plain integer arithmetic on the beat's values.
    function automatic res_t model(input logic [LANES*EW-1:0] fa, input logic [LANES*EW-1:0] fb,
                                   input logic [LANES*AW-1:0] fc, input logic [LANES-1:0] fm,
                                   input logic fsg, input logic fst, input logic fac);
        res_t   r;
        longint smax, smin, umax;
        smax = (longint'(1) <<< (AW-1)) - 1;
        smin = -(longint'(1) <<< (AW-1));
        umax = (longint'(1) <<< AW) - 1;
        r.cyc = 0;
        r.y = '0;
        r.s = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [EW-1:0] ea, eb;
            logic [AW-1:0] raw;
            longint p, ad, s, o;
            ea  = fa[i*EW +: EW];
            eb  = fb[i*EW +: EW];
            raw = fac ? mdl_acc[i] : fc[i*AW +: AW];
            if (fsg) begin
                p  = longint'($signed(ea)) * longint'($signed(eb));
                ad = longint'($signed(raw));
            end else begin
                p  = longint'(ea) * longint'(eb);
                ad = longint'(raw);
            end
            s = p + ad;
            o = s;
            if (fm[i]) begin
                r.y[i*AW +: AW] = raw;
            end else begin
                if (fst && fsg && s > smax)       begin o = smax; r.s[i] = 1'b1; end
                else if (fst && fsg && s < smin)  begin o = smin; r.s[i] = 1'b1; end
                else if (fst && !fsg && s > umax) begin o = umax; r.s[i] = 1'b1; end
                else if (fst && !fsg && s < 0)    begin o = 0;    r.s[i] = 1'b1; end
                r.y[i*AW +: AW] = o[AW-1:0];
                mdl_acc[i] = o[AW-1:0];
            end
        end
        return r;
    endfunction

    function automatic logic [LANES*EW-1:0] ab_all(input logic [EW-1:0] v);
        logic [LANES*EW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*EW +: EW] = v;
        return r;
    endfunction

    function automatic logic [LANES*AW-1:0] c_all(input logic [AW-1:0] v);
        logic [LANES*AW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*AW +: AW] = v;
        return r;
    endfunction

    function automatic logic [LANES*EW-1:0] rnd_ab();
        logic [LANES*EW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*EW +: EW] = EW'($urandom);
        return r;
    endfunction

    function automatic logic [LANES*AW-1:0] rnd_c();
        logic [LANES*AW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*AW +: AW] = AW'($urandom);
        return r;
    endfunction

    // Drive one beat and hold it until accepted. Entered and left at posedge+1.
    task automatic send_beat(input logic [LANES*EW-1:0] ta, input logic [LANES*EW-1:0] tbv,
                             input logic [LANES*AW-1:0] tc, input logic [LANES-1:0] tm,
                             input logic tsg, input logic tst, input logic tac, output int acyc);
        in_valid = 1'b1; a = ta; b = tbv; c = tc; lane_mask = tm;
        op_signed = tsg; op_sat = tst; op_acc = tac;
        acyc = -1;
        for (int k = 0; k < 1000 && acyc < 0; k++) begin
            @(negedge clk);
            if (in_ready) begin
                acyc = cyc;
                exp_q.push_back(model(ta, tbv, tc, tm, tsg, tst, tac));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (acyc < 0) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: in_ready never high, need acceptance");
        end
    endtask

    task automatic wait_rcv(input int n, output bit ok);
        ok = 0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            if (rcv_q.size() >= n) ok = 1;
            else begin @(posedge clk); #1; end
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < LANES; i++) mdl_acc[i] = '0;
        exp_q.delete();
        rcv_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < LANES; i++) mdl_acc[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
        n_vec++; if (y !== '0) begin n_err++; $display("FAIL rst_y: got %h need 0", y); end
        n_vec++; if (y_sat !== '0) begin n_err++; $display("FAIL rst_y_sat: got %b need 0", y_sat); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b need 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid_post: got %b need 0", out_valid); end
    endtask

    // signed -3*7+100 = 79 in every lane, three cycles after acceptance
    task automatic test_basic();
        int ac; bit ok; res_t r;
        out_ready = 1'b1;
        send_beat(ab_all(16'hFFFD), ab_all(16'd7), c_all(32'd100), '0, 1'b1, 1'b0, 1'b0, ac);
        wait_rcv(1, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL basic_timeout: no output beat"); end
        else begin
            r = rcv_q.pop_front();
            if (r.y !== c_all(32'd79)) begin n_err++; $display("FAIL basic_y: got %h need %h", r.y, c_all(32'd79)); end
            n_vec++; if (r.s !== '0) begin n_err++; $display("FAIL basic_sat: got %b need 0", r.s); end
            n_vec++; if (r.cyc - ac !== 3) begin n_err++; $display("FAIL basic_latency: got %0d need 3", r.cyc - ac); end
        end
        exp_q.delete(); rcv_q.delete();
    endtask

    // 10, 20, 30, 40 on consecutive cycles through the accumulator
    task automatic test_back_to_back();
        int ac; bit ok; res_t r; int prev;
        out_ready = 1'b1;
        send_beat(ab_all(16'd2), ab_all(16'd5), c_all(32'd0), '0, 1'b0, 1'b0, 1'b0, ac);
        for (int k = 0; k < 3; k++)
            send_beat(ab_all(16'd2), ab_all(16'd5), c_all(32'd7), '0, 1'b0, 1'b0, 1'b1, ac);
        wait_rcv(4, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL b2b_timeout: got %0d beats need 4", rcv_q.size()); end
        else begin
            prev = 0;
            for (int k = 0; k < 4; k++) begin
                logic [AW-1:0] ev;
                ev = AW'(10 * (k + 1));
                r = rcv_q.pop_front();
                n_vec++;
                if (r.y !== c_all(ev)) begin n_err++; $display("FAIL b2b_y%0d: got %h need %h", k, r.y, c_all(ev)); end
                if (k > 0) begin
                    n_vec++;
                    if (r.cyc !== prev + 1) begin n_err++; $display("FAIL b2b_gap%0d: got cycle %0d need %0d", k, r.cyc, prev + 1); end
                end
                prev = r.cyc;
            end
        end
        exp_q.delete(); rcv_q.delete();
    endtask

    task automatic test_saturation();
        int ac; bit ok; res_t r;
        logic [LANES*AW-1:0] ey[4];
        logic [LANES-1:0]    es[4];
        out_ready = 1'b1;
        // (-32768)^2 = 0x40000000; + 0x7FFFFFFF overflows signed range
        send_beat(ab_all(16'h8000), ab_all(16'h8000), c_all(32'h7FFFFFFF), '0, 1'b1, 1'b1, 1'b0, ac);
        ey[0] = c_all(32'h7FFFFFFF); es[0] = '1;
        // wrap keeps the low 32 bits of 0x40000000 + 0x7FFFFFFF
        send_beat(ab_all(16'h8000), ab_all(16'h8000), c_all(32'h7FFFFFFF), '0, 1'b1, 1'b0, 1'b0, ac);
        ey[1] = c_all(32'hBFFFFFFF); es[1] = '0;
        // unsigned 0xFFFF^2 + 0xFFFFFFFF exceeds 2^32-1
        send_beat(ab_all(16'hFFFF), ab_all(16'hFFFF), c_all(32'hFFFFFFFF), '0, 1'b0, 1'b1, 1'b0, ac);
        ey[2] = c_all(32'hFFFFFFFF); es[2] = '1;
        // -32768*32767 + (-2^31) falls below the signed minimum
        send_beat(ab_all(16'h8000), ab_all(16'h7FFF), c_all(32'h80000000), '0, 1'b1, 1'b1, 1'b0, ac);
        ey[3] = c_all(32'h80000000); es[3] = '1;
        wait_rcv(4, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL sat_timeout: got %0d beats need 4", rcv_q.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                r = rcv_q.pop_front();
                n_vec++; if (r.y !== ey[k]) begin n_err++; $display("FAIL sat_y%0d: got %h need %h", k, r.y, ey[k]); end
                n_vec++; if (r.s !== es[k]) begin n_err++; $display("FAIL sat_flag%0d: got %b need %b", k, r.s, es[k]); end
            end
        end
        exp_q.delete(); rcv_q.delete();
    endtask

    task automatic test_mask();
        int ac; bit ok; res_t r;
        logic [LANES*AW-1:0] ey[4];
        out_ready = 1'b1;
        send_beat(ab_all(16'd2), ab_all(16'd5), c_all(32'd0), '0, 1'b0, 1'b0, 1'b0, ac);
        ey[0] = c_all(32'd10);
        send_beat(ab_all(16'd2), ab_all(16'd5), c_all(32'd999), 4'b0101, 1'b0, 1'b0, 1'b1, ac);
        ey[1] = {32'd20, 32'd10, 32'd20, 32'd10};
        // read back the accumulators: masked lanes must still hold 10
        send_beat(ab_all(16'd0), ab_all(16'd0), c_all(32'd999), '0, 1'b0, 1'b0, 1'b1, ac);
        ey[2] = {32'd20, 32'd10, 32'd20, 32'd10};
        // masked lanes with op_acc=0 pass c, even where the product would saturate
        send_beat(ab_all(16'h8000), ab_all(16'h8000), c_all(32'd555), '1, 1'b1, 1'b1, 1'b0, ac);
        ey[3] = c_all(32'd555);
        wait_rcv(4, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL mask_timeout: got %0d beats need 4", rcv_q.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                r = rcv_q.pop_front();
                n_vec++; if (r.y !== ey[k]) begin n_err++; $display("FAIL mask_y%0d: got %h need %h", k, r.y, ey[k]); end
                n_vec++; if (r.s !== '0) begin n_err++; $display("FAIL mask_flag%0d: got %b need 0", k, r.s); end
            end
        end
        exp_q.delete(); rcv_q.delete();
    endtask

    task automatic test_stall_reset();
        int ac; bit ok; res_t r, e;
        logic [LANES*AW-1:0] ys;
        out_ready = 1'b1;
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send_beat(rnd_ab(), rnd_ab(), rnd_c(), '0, 1'($urandom), 1'($urandom), 1'b1, ac);
            end
            begin
                repeat (4) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                @(negedge clk);
                ys = y;
                repeat (4) begin
                    @(negedge clk);
                    n_vec++;
                    if (y !== ys || out_valid !== 1'b1) begin
                        n_err++;
                        $display("FAIL stall_hold: got y=%h v=%b need y=%h v=1", y, out_valid, ys);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_rcv(6, ok);
        n_vec++;
        if (!ok || rcv_q.size() != 6) begin
            n_err++; $display("FAIL stall_count: got %0d beats need 6", rcv_q.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                r = rcv_q.pop_front(); e = exp_q.pop_front();
                n_vec++;
                if (r.y !== e.y || r.s !== e.s) begin
                    n_err++; $display("FAIL stall_beat%0d: got %h/%b need %h/%b", k, r.y, r.s, e.y, e.s);
                end
            end
        end
        exp_q.delete(); rcv_q.delete();

        // Leave beats in flight (one visible, one behind it), then reset.
        out_ready = 1'b0;
        send_beat(rnd_ab(), rnd_ab(), rnd_c(), '0, 1'b0, 1'b0, 1'b0, ac);
        send_beat(rnd_ab(), rnd_ab(), rnd_c(), '0, 1'b0, 1'b0, 1'b0, ac);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_rst_valid: got %b need 0", out_valid); end
        n_vec++; if (y !== '0 || y_sat !== '0) begin n_err++; $display("FAIL async_rst_y: got %h/%b need 0", y, y_sat); end
        @(posedge clk); #1;
        pulse_reset();
        out_ready = 1'b1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_ready: got %b need 1", in_ready); end
        repeat (5) begin @(posedge clk); #1; end
        n_vec++; if (rcv_q.size() != 0) begin n_err++; $display("FAIL post_rst_ghost: got %0d beats need 0", rcv_q.size()); end
        send_beat(ab_all(16'd0), ab_all(16'd0), c_all(32'd77), '0, 1'b0, 1'b0, 1'b1, ac);
        wait_rcv(1, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL acc_clear_timeout: no output beat"); end
        else begin
            r = rcv_q.pop_front();
            if (r.y !== '0) begin n_err++; $display("FAIL acc_clear: got %h need 0", r.y); end
        end
        exp_q.delete(); rcv_q.delete();
    endtask

    task automatic test_random();
        int ac; bit ok; res_t r, e;
        logic [LANES-1:0] m;
        rnd_done = 0;
        out_ready = 1'b1;
        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
                    m = ($urandom_range(0, 3) == 0) ? LANES'($urandom) : '0;
                    send_beat(rnd_ab(), rnd_ab(), rnd_c(), m, 1'($urandom), 1'($urandom),
                              1'($urandom), ac);
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_rcv(300, ok);
        n_vec++;
        if (!ok || rcv_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rnd_count: got %0d beats need %0d", rcv_q.size(), exp_q.size());
        end
        while (rcv_q.size() > 0 && exp_q.size() > 0) begin
            r = rcv_q.pop_front(); e = exp_q.pop_front();
            n_vec++;
            if (r.y !== e.y || r.s !== e.s) begin
                n_err++; $display("FAIL rnd_beat: got %h/%b need %h/%b", r.y, r.s, e.y, e.s);
            end
        end
        exp_q.delete(); rcv_q.delete();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_saturation();
        test_mask();
        test_stall_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
